// File: rtl/instr_reg_arbiter_if.sv
// ---------------------------------------------------------------------------
// instr_reg_arbiter_if
// Bundle of every handshake, payload, register-write and read-sequencing
// signal of instr_reg_arbiter. Only clk and reset_n stay outside it.
//
//   master : requester / environment side (drives requests and payloads)
//   slave  : arbiter side (drives ready, register write port and read status)
//
// Signals
//   req_valid[1:0] / req_ready[1:0] : write handshake, bit 0 = A, bit 1 = B
//   a_*/b_* payloads                 : opcode (OPW) and two signed 32-bit operands
//   load_en, write_pointer, opcode,
//   operand_a, operand_b             : register-file write port
//   rd_req, rd_addr                  : read request
//   read_pointer, rd_valid, rd_err   : read sequencing
//   full, count                      : occupancy
// ---------------------------------------------------------------------------
interface instr_reg_arbiter_if #(
  parameter int DEPTH = 32,
  parameter int OPW   = 4
);
  localparam int PW = $clog2(DEPTH);

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [OPW-1:0]     a_opcode;
  logic [OPW-1:0]     b_opcode;
  logic signed [31:0] a_operand_a;
  logic signed [31:0] a_operand_b;
  logic signed [31:0] b_operand_a;
  logic signed [31:0] b_operand_b;

  logic               load_en;
  logic [PW-1:0]      write_pointer;
  logic [OPW-1:0]     opcode;
  logic signed [31:0] operand_a;
  logic signed [31:0] operand_b;

  logic               rd_req;
  logic [PW-1:0]      rd_addr;
  logic [PW-1:0]      read_pointer;
  logic               rd_valid;
  logic               rd_err;

  logic               full;
  logic [PW:0]        count;

  modport master (
    output req_valid, a_opcode, b_opcode,
           a_operand_a, a_operand_b, b_operand_a, b_operand_b,
           rd_req, rd_addr,
    input  req_ready, load_en, write_pointer, opcode, operand_a, operand_b,
           read_pointer, rd_valid, rd_err, full, count
  );

  modport slave (
    input  req_valid, a_opcode, b_opcode,
           a_operand_a, a_operand_b, b_operand_a, b_operand_b,
           rd_req, rd_addr,
    output req_ready, load_en, write_pointer, opcode, operand_a, operand_b,
           read_pointer, rd_valid, rd_err, full, count
  );
endinterface

// File: rtl/instr_reg_arbiter.sv
// ---------------------------------------------------------------------------
// instr_reg_arbiter
// Two-requester round-robin arbiter in front of an instruction register
// file. The granted payload is registered and presented on the write port
// (load_en pulse, write_pointer = allocation pointer) one cycle after
// acceptance. A written-mask tracks which locations have ever been loaded
// so that reads of never-written locations are flagged with rd_err.
//
// Ports
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : instr_reg_arbiter_if.slave (handshake, payloads, write port,
//             read request/status, occupancy)
//
// Configuration
//   INSTR_ARB_WRAP_EN : when defined the arbiter never stalls on full; the
//                       allocation pointer wraps and overwrites the oldest
//                       entry, count saturates at DEPTH and full is only a
//                       status flag. When undefined, req_ready drops to 00
//                       once full and stays there until reset.
// ---------------------------------------------------------------------------
module instr_reg_arbiter #(
  parameter int DEPTH = 32,
  parameter int OPW   = 4
) (
  input logic               clk,
  input logic               reset_n,
  instr_reg_arbiter_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  // Last-grant encoding: which requester won the most recent arbitration.
  localparam logic LG_A = 1'b0;
  localparam logic LG_B = 1'b1;

  // Round-robin pick among valid requesters; last_b says B won last time.
  function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last_b);
    logic [1:0] pick;
    case (valid)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_b ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic               load_en_q,       load_en_d;
  logic [PW-1:0]      write_pointer_q, write_pointer_d;
  logic [OPW-1:0]     opcode_q,        opcode_d;
  logic signed [31:0] operand_a_q,     operand_a_d;
  logic signed [31:0] operand_b_q,     operand_b_d;
  logic [PW-1:0]      wptr_q,          wptr_d;
  logic [CW-1:0]      count_q,         count_d;
  logic               full_q,          full_d;
  logic [DEPTH-1:0]   mask_q,          mask_d;
  logic               last_grant_q,    last_grant_d;
  logic [PW-1:0]      read_pointer_q,  read_pointer_d;
  logic               rd_pend_q,       rd_pend_d;
  logic               rd_pend_err_q,   rd_pend_err_d;
  logic               rd_valid_q,      rd_valid_d;
  logic               rd_err_q,        rd_err_d;

  logic [1:0]         grant_s;
  logic               accept_s;
  logic               stall_s;
  logic               rd_hit_s;

  // Full-stall policy selected at build time.
`ifdef INSTR_ARB_WRAP_EN
  assign stall_s = 1'b0;
`else
  assign stall_s = full_q;
`endif

  // Grant generation. reset_n gates the grant directly so that req_ready
  // is 00 for the whole time reset is held, not just from the next edge.
  always_comb begin
    grant_s = 2'b00;
    if (!reset_n) begin
      grant_s = 2'b00;
    end else if (stall_s) begin
      grant_s = 2'b00;
    end else begin
      grant_s = rr_pick(bus.req_valid, last_grant_q);
    end
  end

  assign accept_s = |grant_s;

  // Location is readable if already written, or being written this very
  // cycle (the write commits before the read data is sampled).
  always_comb begin
    rd_hit_s = mask_q[bus.rd_addr];
    if (accept_s && (wptr_q == bus.rd_addr)) begin
      rd_hit_s = 1'b1;
    end else begin
      rd_hit_s = mask_q[bus.rd_addr];
    end
  end

  // Write-side next state: payload capture, pointer, count, mask, last grant.
  always_comb begin
    load_en_d       = accept_s;
    write_pointer_d = write_pointer_q;
    opcode_d        = opcode_q;
    operand_a_d     = operand_a_q;
    operand_b_d     = operand_b_q;
    wptr_d          = wptr_q;
    count_d         = count_q;
    mask_d          = mask_q;
    last_grant_d    = last_grant_q;
    if (accept_s) begin
      write_pointer_d = wptr_q;
      if (grant_s[1]) begin
        opcode_d     = bus.b_opcode;
        operand_a_d  = bus.b_operand_a;
        operand_b_d  = bus.b_operand_b;
        last_grant_d = LG_B;
      end else begin
        opcode_d     = bus.a_opcode;
        operand_a_d  = bus.a_operand_a;
        operand_b_d  = bus.a_operand_b;
        last_grant_d = LG_A;
      end
      if (wptr_q == LAST_PTR) begin
        wptr_d = {PW{1'b0}};
      end else begin
        wptr_d = wptr_q + PW'(1);
      end
      if (count_q != DEPTH_CNT) begin
        count_d = count_q + CW'(1);
      end else begin
        count_d = count_q;
      end
      mask_d[wptr_q] = 1'b1;
    end else begin
      write_pointer_d = write_pointer_q;
    end
    full_d = (count_d == DEPTH_CNT);
  end

  // Read-side next state: two-stage pipeline, pointer then valid/error.
  always_comb begin
    read_pointer_d = read_pointer_q;
    rd_pend_d      = 1'b0;
    rd_pend_err_d  = 1'b0;
    if (bus.rd_req) begin
      read_pointer_d = bus.rd_addr;
      rd_pend_d      = 1'b1;
      rd_pend_err_d  = ~rd_hit_s;
    end else begin
      read_pointer_d = read_pointer_q;
    end
    rd_valid_d = rd_pend_q;
    rd_err_d   = rd_pend_q & rd_pend_err_q;
  end

  // State registers; reset also drops any write or read in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_en_q       <= 1'b0;
      write_pointer_q <= {PW{1'b0}};
      opcode_q        <= {OPW{1'b0}};
      operand_a_q     <= 32'sd0;
      operand_b_q     <= 32'sd0;
      wptr_q          <= {PW{1'b0}};
      count_q         <= {CW{1'b0}};
      full_q          <= 1'b0;
      mask_q          <= {DEPTH{1'b0}};
      last_grant_q    <= LG_B;
      read_pointer_q  <= LAST_PTR;
      rd_pend_q       <= 1'b0;
      rd_pend_err_q   <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_err_q        <= 1'b0;
    end else begin
      load_en_q       <= load_en_d;
      write_pointer_q <= write_pointer_d;
      opcode_q        <= opcode_d;
      operand_a_q     <= operand_a_d;
      operand_b_q     <= operand_b_d;
      wptr_q          <= wptr_d;
      count_q         <= count_d;
      full_q          <= full_d;
      mask_q          <= mask_d;
      last_grant_q    <= last_grant_d;
      read_pointer_q  <= read_pointer_d;
      rd_pend_q       <= rd_pend_d;
      rd_pend_err_q   <= rd_pend_err_d;
      rd_valid_q      <= rd_valid_d;
      rd_err_q        <= rd_err_d;
    end
  end

  assign bus.req_ready     = grant_s;
  assign bus.load_en       = load_en_q;
  assign bus.write_pointer = write_pointer_q;
  assign bus.opcode        = opcode_q;
  assign bus.operand_a     = operand_a_q;
  assign bus.operand_b     = operand_b_q;
  assign bus.read_pointer  = read_pointer_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_err        = rd_err_q;
  assign bus.full          = full_q;
  assign bus.count         = count_q;

endmodule

// File: tb/tb_instr_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_instr_reg_arbiter
// Directed-vector bench for instr_reg_arbiter (DEPTH=32, OPW=4). Inputs are
// driven 1 ns after the rising edge; outputs are checked before the next
// edge. Build with INSTR_ARB_WRAP_EN defined to run the wrap scenario
// instead of the stall-on-full scenario.
// ---------------------------------------------------------------------------
module tb_instr_reg_arbiter;

  logic clk;
  logic reset_n;

  instr_reg_arbiter_if #(.DEPTH(32), .OPW(4)) bus_if ();

  instr_reg_arbiter #(.DEPTH(32), .OPW(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  int nvec = 0;
  int nmis = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.req_valid   = 2'b00;
    bus_if.a_opcode    = 4'd0;
    bus_if.b_opcode    = 4'd0;
    bus_if.a_operand_a = 32'sd0;
    bus_if.a_operand_b = 32'sd0;
    bus_if.b_operand_a = 32'sd0;
    bus_if.b_operand_b = 32'sd0;
    bus_if.rd_req      = 1'b0;
    bus_if.rd_addr     = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".req_ready"},     64'(bus_if.req_ready),     64'd0);
    chk({tag, ".load_en"},       64'(bus_if.load_en),       64'd0);
    chk({tag, ".write_pointer"}, 64'(bus_if.write_pointer), 64'd0);
    chk({tag, ".opcode"},        64'(bus_if.opcode),        64'd0);
    chk({tag, ".operand_a"},     64'(bus_if.operand_a),     64'd0);
    chk({tag, ".operand_b"},     64'(bus_if.operand_b),     64'd0);
    chk({tag, ".read_pointer"},  64'(bus_if.read_pointer),  64'd31);
    chk({tag, ".rd_valid"},      64'(bus_if.rd_valid),      64'd0);
    chk({tag, ".rd_err"},        64'(bus_if.rd_err),        64'd0);
    chk({tag, ".full"},          64'(bus_if.full),          64'd0);
    chk({tag, ".count"},         64'(bus_if.count),         64'd0);
  endtask

  logic signed [31:0] neg7;
  logic [63:0]        neg7_x;

  initial begin
    neg7   = -32'sd7;
    neg7_x = 64'(neg7);

    // Reset state, with both requesters shouting during reset.
    idle_inputs();
    reset_n = 1'b0;
    bus_if.req_valid = 2'b11;
    #13;
    chk_reset_values("rst");

    // First write right after release: A op=1, a=5, b=3.
    tick();
    reset_n = 1'b1;
    bus_if.req_valid   = 2'b01;
    bus_if.a_opcode    = 4'd1;
    bus_if.a_operand_a = 32'sd5;
    bus_if.a_operand_b = 32'sd3;
    #1;
    chk("first.ready", 64'(bus_if.req_ready), 64'b01);
    tick();
    bus_if.req_valid = 2'b00;
    chk("first.load_en", 64'(bus_if.load_en),       64'd1);
    chk("first.wp",      64'(bus_if.write_pointer), 64'd0);
    chk("first.opcode",  64'(bus_if.opcode),        64'd1);
    chk("first.op_a",    64'(bus_if.operand_a),     64'd5);
    chk("first.op_b",    64'(bus_if.operand_b),     64'd3);
    chk("first.count",   64'(bus_if.count),         64'd1);
    tick();
    chk("first.load_off", 64'(bus_if.load_en), 64'd0);

    // Round robin from reset: A, B, A, B into locations 0..3.
    do_reset();
    bus_if.req_valid   = 2'b11;
    bus_if.a_opcode    = 4'd2;
    bus_if.b_opcode    = 4'd3;
    bus_if.a_operand_a = 32'sd11;
    bus_if.b_operand_a = neg7;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr.ready", 64'(bus_if.req_ready), (i % 2 == 0) ? 64'b01 : 64'b10);
      tick();
      chk("rr.load_en", 64'(bus_if.load_en),       64'd1);
      chk("rr.wp",      64'(bus_if.write_pointer), 64'(i));
      chk("rr.opcode",  64'(bus_if.opcode),        (i % 2 == 0) ? 64'd2 : 64'd3);
      chk("rr.op_a",    64'(bus_if.operand_a),     (i % 2 == 0) ? 64'd11 : neg7_x);
    end
    bus_if.req_valid = 2'b00;
    chk("rr.count", 64'(bus_if.count), 64'd4);

    // Reads after 3 writes: addr 2 is written, addr 7 is not.
    do_reset();
    bus_if.req_valid = 2'b01;
    tick(); tick(); tick();
    bus_if.req_valid = 2'b00;
    bus_if.rd_req  = 1'b1;
    bus_if.rd_addr = 5'd2;
    tick();
    chk("rd.ptr2",    64'(bus_if.read_pointer), 64'd2);
    chk("rd.early",   64'(bus_if.rd_valid),     64'd0);
    bus_if.rd_addr = 5'd7;
    tick();
    bus_if.rd_req = 1'b0;
    chk("rd.ptr7",    64'(bus_if.read_pointer), 64'd7);
    chk("rd.valid2",  64'(bus_if.rd_valid),     64'd1);
    chk("rd.err2",    64'(bus_if.rd_err),       64'd0);
    tick();
    chk("rd.valid7",  64'(bus_if.rd_valid),     64'd1);
    chk("rd.err7",    64'(bus_if.rd_err),       64'd1);
    chk("rd.hold",    64'(bus_if.read_pointer), 64'd7);
    tick();
    chk("rd.done",    64'(bus_if.rd_valid),     64'd0);

    // Read of the location being written in the same cycle (wptr=3).
    bus_if.req_valid = 2'b10;
    bus_if.rd_req    = 1'b1;
    bus_if.rd_addr   = 5'd3;
    tick();
    bus_if.req_valid = 2'b00;
    bus_if.rd_req    = 1'b0;
    chk("same.wp", 64'(bus_if.write_pointer), 64'd3);
    tick();
    chk("same.valid", 64'(bus_if.rd_valid), 64'd1);
    chk("same.err",   64'(bus_if.rd_err),   64'd0);
    chk("same.count", 64'(bus_if.count),    64'd4);

    // Reset in the acceptance cycle, and right after a captured write/read.
    bus_if.req_valid = 2'b01;
    bus_if.a_opcode  = 4'd9;
    bus_if.rd_req    = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_values("abort");
    tick();
    reset_n = 1'b1;
    idle_inputs();
    bus_if.req_valid = 2'b01;
    tick();
    bus_if.rd_req    = 1'b1;
    bus_if.req_valid = 2'b00;
    tick();
    bus_if.rd_req = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("abort2.load_en",  64'(bus_if.load_en),  64'd0);
    chk("abort2.count",    64'(bus_if.count),    64'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post.load_en",  64'(bus_if.load_en),  64'd0);
      chk("post.rd_valid", 64'(bus_if.rd_valid), 64'd0);
    end

    // Fill all 32 locations from A.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      bus_if.req_valid = 2'b01;
      bus_if.a_opcode  = 4'(i);
      #1;
      chk("fill.ready", 64'(bus_if.req_ready), 64'b01);
      tick();
      chk("fill.wp", 64'(bus_if.write_pointer), 64'(i));
    end
    chk("fill.full",  64'(bus_if.full),  64'd1);
    chk("fill.count", 64'(bus_if.count), 64'd32);
`ifdef INSTR_ARB_WRAP_EN
    // 33rd write wraps onto location 0.
    #1;
    chk("wrap.ready", 64'(bus_if.req_ready), 64'b01);
    tick();
    bus_if.req_valid = 2'b00;
    chk("wrap.load_en", 64'(bus_if.load_en),       64'd1);
    chk("wrap.wp",      64'(bus_if.write_pointer), 64'd0);
    chk("wrap.full",    64'(bus_if.full),          64'd1);
    chk("wrap.count",   64'(bus_if.count),         64'd32);
`else
    // Once full, nothing more is accepted.
    bus_if.req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.ready", 64'(bus_if.req_ready), 64'b00);
      tick();
      chk("stall.load_en", 64'(bus_if.load_en), 64'd0);
      chk("stall.count",   64'(bus_if.count),   64'd32);
    end
    bus_if.req_valid = 2'b10;
    #1;
    chk("stall.ready_b", 64'(bus_if.req_ready), 64'b00);
    bus_if.req_valid = 2'b00;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  // Runaway guard.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/instr_reg_arbiter.md
INSTR_REG_ARBITER -- requirements
Module: instr_reg_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of instruction register locations; pointer width PW = $clog2(DEPTH).
REQ-002 SHALL have parameter OPW, default 4: opcode width; operands are fixed at 32-bit signed.
REQ-003 SHALL have port clk, input, 1: sole clock, all state updates on posedge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports req_valid, input, 2, and req_ready, output, 2: per-requester write handshake, where index 0 is requester A and index 1 is requester B.
REQ-006 SHALL have ports a_opcode/b_opcode, input, OPW, and a_operand_a/a_operand_b/b_operand_a/b_operand_b, input, 32: write payloads.
REQ-007 SHALL have ports load_en, output, 1; write_pointer, output, PW; opcode, output, OPW; operand_a/operand_b, output, 32: drive the register write port.
REQ-008 SHALL have ports rd_req, input, 1, and rd_addr, input, PW: read request.
REQ-009 SHALL have ports read_pointer, output, PW; rd_valid, output, 1; rd_err, output, 1: read sequencing.
REQ-010 SHALL have ports full, output, 1, and count, output, PW+1: occupancy.

Function
REQ-011 SHALL accept a write from requester i in a cycle where req_valid[i] && req_ready[i].
REQ-012 SHALL compute req_ready combinationally: at most one bit set; both bits zero when full=1 (without the wrap macro).
REQ-013 SHALL arbitrate round-robin: if only one requester is valid, it is granted; if both are valid, the requester not granted last is granted; after reset, A has priority.
REQ-014 SHALL register the accepted payload and assert load_en for exactly one cycle, the cycle after acceptance, with write_pointer = current wptr.
REQ-015 SHALL increment wptr after each accepted write, wrapping DEPTH-1 -> 0.
REQ-016 SHALL support back-to-back writes, one per cycle, with no bubble.
REQ-017 SHALL increment count on every accepted write, saturating at DEPTH; full = (count == DEPTH).
REQ-018 SHALL keep a DEPTH-bit written-mask, setting bit wptr on each accepted write.
REQ-019 SHALL, on rd_req, register read_pointer <= rd_addr, then assert rd_valid one cycle later for one cycle.
REQ-020 SHALL assert rd_err together with rd_valid if the mask bit for the read address was clear at the time of the request.
REQ-021 SHALL allow a read and a write in the same cycle.
REQ-022 SHALL, when a read addresses the location being written in the same cycle, report rd_err=0, because the write is committed before the data is sampled.
REQ-023 SHALL hold read_pointer unchanged while rd_req=0.

Reset
REQ-024 SHALL, while reset_n=0, force: req_ready=0, load_en=0, write_pointer=0, opcode=0, operand_a=0, operand_b=0, read_pointer=DEPTH-1, rd_valid=0, rd_err=0, full=0, count=0, wptr=0, mask=0, last-grant=B.
REQ-025 SHALL abort any in-flight write or read when reset is asserted mid-operation; no load_en or rd_valid pulse may follow reset release without a new request.
REQ-026 SHALL accept the first request in the first posedge after reset_n deasserts.

Configuration
REQ-027 SHALL recognise the macro INSTR_ARB_WRAP_EN.
REQ-028 SHALL, when INSTR_ARB_WRAP_EN is defined, never stall for full: writes continue, wptr wraps and overwrites the oldest entry, count stays at DEPTH, and full is a status flag only.
REQ-029 SHALL, when INSTR_ARB_WRAP_EN is undefined, deassert req_ready once full=1 and leave it deasserted until reset.

Verification
REQ-030 SHALL pass: reset, then A writes opcode=1, op_a=5, op_b=3 -> load_en on the next cycle, write_pointer=0, count=1.
REQ-031 SHALL pass: A and B valid for 4 cycles -> grants A, B, A, B; write_pointer 0, 1, 2, 3.
REQ-032 SHALL pass: 32 A writes without the macro -> full=1, req_ready=00 thereafter; a 33rd request is never accepted.
REQ-033 SHALL pass: 33 writes with INSTR_ARB_WRAP_EN -> the 33rd write has write_pointer=0, full=1, count=32.
REQ-034 SHALL pass: after 3 writes, rd_req with rd_addr=2 then rd_addr=7 -> rd_valid with rd_err=0, then rd_valid with rd_err=1.
REQ-035 SHALL pass: reset_n driven low in the cycle after acceptance -> no load_en pulse, all outputs at their reset values.
